inst_fetch: RTL and testbench

Instruction fetch stage that sits directly upstream of the instruction ROM and downstream-facing toward the IF/ID register. It owns the PC, drives the ROM chip-enable and address, and captures each returned instruction with its PC into a small prefetch queue. It presents one {pc, inst} pair per cycle to the decoder under a valid/stall handshake. Branches and exception flushes redirect the PC and discard queued work.

---
 rtl/inst_fetch_pkg.sv | 30 +++
 rtl/inst_fetch_fifo.sv | 68 ++++++
 rtl/inst_fetch.sv | 112 +++++++++++
 tb/tb_inst_fetch.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage:
// bus widths, enable/reset levels, FSM states and the queued fetch entry.
package inst_fetch_pkg;

  localparam int ADDR_W = 32;
  localparam int INST_W = 32;

  localparam logic [INST_W-1:0] ZERO_WORD        = 32'h0000_0000;
  localparam logic              CHIP_ENABLE      = 1'b1;
  localparam logic              CHIP_DISABLE     = 1'b0;
  localparam logic              RST_ENABLE       = 1'b1;
  localparam logic [ADDR_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [ADDR_W-1:0] PC_STEP          = 32'h0000_0004;

  typedef enum logic [0:0] {
    IF_IDLE = 1'b0,
    IF_RUN  = 1'b1
  } if_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

  // Instructions are word aligned, so redirect targets drop their byte offset.
  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
    return {addr[ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/inst_fetch_fifo.sv
// Prefetch queue holding {pc, inst} pairs between the ROM and the decoder.
// clear empties the queue and wins over push/pop in the same cycle.
module inst_fetch_fifo
  import inst_fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       clear,
  input  fetch_entry_t               din,
  output fetch_entry_t               dout,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  fetch_entry_t     mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  // Status flags and qualified push/pop; a full queue accepts a push only alongside a pop.
  always_comb begin
    full      = (count_r == CNT_W'(DEPTH));
    empty     = (count_r == CNT_W'(0));
    pop_ok_s  = pop & ~empty;
    push_ok_s = push & (~full | pop_ok_s);
    count     = count_r;
    dout      = mem_r[rd_ptr_r];
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE || clear) begin
      wr_ptr_r <= PTR_W'(0);
      rd_ptr_r <= PTR_W'(0);
      count_r  <= CNT_W'(0);
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage; contents are only meaningful behind the occupancy count.
  always_ff @(posedge clk) begin
    if (push_ok_s && !clear && rst != RST_ENABLE) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: owns the PC, drives the combinational ROM and
// queues {pc, inst} pairs for the decoder; branches and flushes redirect the PC.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter int                DEPTH    = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic              clk,
  input  logic              rst,
  output logic              rom_ce_o,
  output logic [ADDR_W-1:0] rom_addr_o,
  input  logic [INST_W-1:0] rom_data_i,
  input  logic              stall_i,
  input  logic              branch_i,
  input  logic [ADDR_W-1:0] branch_target_i,
  input  logic              flush_i,
  input  logic [ADDR_W-1:0] new_pc_i,
  output logic              inst_valid_o,
  output logic [INST_W-1:0] inst_o,
  output logic [ADDR_W-1:0] pc_o
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  if_state_e         state_r;
  logic [ADDR_W-1:0] pc_r;
  logic              rom_ce_r;

  logic [CNT_W-1:0]  count_s;
  logic              full_s;
  logic              empty_s;
  fetch_entry_t      head_s;
  fetch_entry_t      entry_s;
  logic              redirect_s;
  logic              pop_s;
  logic              fifo_pop_s;
  logic              fetch_s;

  // Handshake and fetch decision; a redirect suppresses both pop and fetch.
  always_comb begin
    inst_valid_o = (count_s != CNT_W'(0));
    redirect_s   = flush_i | branch_i;
    pop_s        = inst_valid_o & ~stall_i;
    fifo_pop_s   = pop_s & ~redirect_s;
    fetch_s      = (state_r == IF_RUN) & (~full_s | pop_s) & ~redirect_s;
    entry_s      = {pc_r, rom_data_i};
  end

  // Head entry presented to the decoder, zeroed while the queue is empty.
  always_comb begin
    if (empty_s) begin
      inst_o = ZERO_WORD;
      pc_o   = ZERO_WORD;
    end else begin
      inst_o = head_s.inst;
      pc_o   = head_s.pc;
    end
  end

  assign rom_ce_o   = rom_ce_r;
  assign rom_addr_o = pc_r;

  // FSM, chip enable and PC; flush outranks branch, which outranks sequential fetch.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state_r  <= IF_IDLE;
      rom_ce_r <= CHIP_DISABLE;
      pc_r     <= word_align(RESET_PC);
    end else begin
      case (state_r)
        IF_IDLE: begin
          state_r  <= IF_RUN;
          rom_ce_r <= CHIP_ENABLE;
        end
        IF_RUN: begin
          state_r  <= IF_RUN;
          rom_ce_r <= CHIP_ENABLE;
        end
        default: begin
          state_r  <= IF_IDLE;
          rom_ce_r <= CHIP_DISABLE;
        end
      endcase
      if (flush_i) begin
        pc_r <= word_align(new_pc_i);
      end else if (branch_i) begin
        pc_r <= word_align(branch_target_i);
      end else if (fetch_s) begin
        pc_r <= pc_r + PC_STEP;
      end else begin
        pc_r <= pc_r;
      end
    end
  end

  inst_fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (fetch_s),
    .pop  (fifo_pop_s),
    .clear(redirect_s),
    .din  (entry_s),
    .dout (head_s),
    .count(count_s),
    .full (full_s),
    .empty(empty_s)
  );

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: directed scenarios plus randomized
// stall/redirect/reset traffic against a queue-based reference model.
module tb_inst_fetch;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        rom_ce_o;
  logic [31:0] rom_addr_o;
  logic [31:0] rom_data_i;
  logic        stall_i;
  logic        branch_i;
  logic [31:0] branch_target_i;
  logic        flush_i;
  logic [31:0] new_pc_i;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [31:0] pc_o;
  logic [31:0] salt;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  bit          m_run;
  logic [31:0] m_pc;
  logic [63:0] m_q[$];

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_fn(input logic [31:0] a, input logic [31:0] s);
    return (32'h1000_0000 + (a >> 2)) ^ s;
  endfunction

  assign rom_data_i = rom_fn(rom_addr_o, salt);

  wire [97:0] obs_s = {rom_ce_o, rom_addr_o, inst_valid_o, pc_o, inst_o};

  inst_fetch #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .rst            (rst),
    .rom_ce_o       (rom_ce_o),
    .rom_addr_o     (rom_addr_o),
    .rom_data_i     (rom_data_i),
    .stall_i        (stall_i),
    .branch_i       (branch_i),
    .branch_target_i(branch_target_i),
    .flush_i        (flush_i),
    .new_pc_i       (new_pc_i),
    .inst_valid_o   (inst_valid_o),
    .inst_o         (inst_o),
    .pc_o           (pc_o)
  );

  // One clock of the behavioural model, using the inputs about to be sampled.
  task automatic model_step();
    bit pop;
    bit fetch;
    if (rst) begin
      m_run = 1'b0;
      m_pc  = 32'h0000_0000;
      m_q.delete();
    end else begin
      pop = (m_q.size() != 0) && !stall_i;
      if (flush_i) begin
        m_q.delete();
        m_pc = new_pc_i & 32'hFFFF_FFFC;
      end else if (branch_i) begin
        m_q.delete();
        m_pc = branch_target_i & 32'hFFFF_FFFC;
      end else begin
        fetch = m_run && ((m_q.size() < DEPTH) || pop);
        if (pop) void'(m_q.pop_front());
        if (fetch) begin
          m_q.push_back({m_pc, rom_fn(m_pc, salt)});
          m_pc = m_pc + 32'd4;
        end
      end
      m_run = 1'b1;
    end
  endtask

  function automatic logic [97:0] exp_vec();
    logic [63:0] h;
    h = (m_q.size() != 0) ? m_q[0] : 64'h0;
    return {m_run, m_pc, (m_q.size() != 0), h};
  endfunction

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (rom_ce_o !== 1'b0 || inst_valid_o !== 1'b0 || pc_o !== 32'h0 ||
          inst_o !== 32'h0 || rom_addr_o !== 32'h0) begin
        failures++;
        $display("FAIL reset_hold got ce=%b v=%b pc=%h inst=%h addr=%h want all zero",
                 rom_ce_o, inst_valid_o, pc_o, inst_o, rom_addr_o);
      end
    end
    rst = 1'b0;
    tick();
    checks++;
    if (rom_ce_o !== 1'b1 || rom_addr_o !== 32'h0 || inst_valid_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_release1 got ce=%b addr=%h v=%b want ce=1 addr=0 v=0",
               rom_ce_o, rom_addr_o, inst_valid_o);
    end
    tick();
    checks++;
    if (inst_valid_o !== 1'b1 || pc_o !== 32'h0 || inst_o !== 32'h1000_0000) begin
      failures++;
      $display("FAIL reset_release2 got v=%b pc=%h inst=%h want v=1 pc=0 inst=10000000",
               inst_valid_o, pc_o, inst_o);
    end
    checks++;
    if (obs_s !== exp_vec()) begin
      failures++;
      $display("FAIL reset_model got=%h exp=%h", obs_s, exp_vec());
    end
  endtask

  task automatic test_streaming();
    stall_i = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      checks++;
      if (inst_valid_o !== 1'b1 || pc_o !== 32'(4 * k) || inst_o !== 32'h1000_0000 + 32'(k)) begin
        failures++;
        $display("FAIL stream got v=%b pc=%h inst=%h want pc=%h inst=%h",
                 inst_valid_o, pc_o, inst_o, 32'(4 * k), 32'h1000_0000 + 32'(k));
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] h;
    h = pc_o;
    stall_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (inst_valid_o !== 1'b1 || pc_o !== h || rom_addr_o !== h + 32'd8 || rom_ce_o !== 1'b1) begin
        failures++;
        $display("FAIL stall_hold got v=%b pc=%h addr=%h ce=%b want pc=%h addr=%h",
                 inst_valid_o, pc_o, rom_addr_o, rom_ce_o, h, h + 32'd8);
      end
    end
    stall_i = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      tick();
      checks++;
      if (pc_o !== h + 32'(4 * k) || inst_o !== rom_fn(h + 32'(4 * k), salt)) begin
        failures++;
        $display("FAIL stall_release got pc=%h inst=%h want pc=%h", pc_o, inst_o, h + 32'(4 * k));
      end
    end
    checks++;
    if (obs_s !== exp_vec()) begin
      failures++;
      $display("FAIL backpressure_model got=%h exp=%h", obs_s, exp_vec());
    end
  endtask

  task automatic test_branch();
    stall_i = 1'b1;
    tick();
    tick();
    branch_i        = 1'b1;
    branch_target_i = 32'h0000_0103;
    tick();
    checks++;
    if (inst_valid_o !== 1'b0 || rom_addr_o !== 32'h0000_0100) begin
      failures++;
      $display("FAIL branch_redirect got v=%b addr=%h want v=0 addr=00000100", inst_valid_o, rom_addr_o);
    end
    branch_i = 1'b0;
    stall_i  = 1'b0;
    tick();
    checks++;
    if (inst_valid_o !== 1'b1 || pc_o !== 32'h0000_0100 || inst_o !== rom_fn(32'h100, salt)) begin
      failures++;
      $display("FAIL branch_target got v=%b pc=%h inst=%h want pc=00000100", inst_valid_o, pc_o, inst_o);
    end
  endtask

  task automatic test_flush_vs_branch();
    stall_i = 1'b1;
    tick();
    tick();
    flush_i         = 1'b1;
    new_pc_i        = 32'h0000_0200;
    branch_i        = 1'b1;
    branch_target_i = 32'h0000_0300;
    tick();
    checks++;
    if (rom_addr_o !== 32'h0000_0200 || inst_valid_o !== 1'b0) begin
      failures++;
      $display("FAIL flush_priority got addr=%h v=%b want addr=00000200 v=0", rom_addr_o, inst_valid_o);
    end
    flush_i  = 1'b0;
    branch_i = 1'b0;
    stall_i  = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if (inst_valid_o !== 1'b1 || pc_o !== 32'h0000_0200 + 32'(4 * k)) begin
        failures++;
        $display("FAIL flush_stream got v=%b pc=%h want pc=%h", inst_valid_o, pc_o, 32'h200 + 32'(4 * k));
      end
    end
  endtask

  task automatic test_wrap_and_reset();
    logic [31:0] want [3];
    want[0] = 32'hFFFF_FFF8;
    want[1] = 32'hFFFF_FFFC;
    want[2] = 32'h0000_0000;
    branch_i        = 1'b1;
    branch_target_i = 32'hFFFF_FFF8;
    tick();
    branch_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (inst_valid_o !== 1'b1 || pc_o !== want[k] || inst_o !== rom_fn(want[k], salt)) begin
        failures++;
        $display("FAIL wrap got v=%b pc=%h inst=%h want pc=%h", inst_valid_o, pc_o, inst_o, want[k]);
      end
    end
    stall_i = 1'b1;
    tick();
    tick();
    checks++;
    if (obs_s !== exp_vec()) begin
      failures++;
      $display("FAIL wrap_model got=%h exp=%h", obs_s, exp_vec());
    end
    rst = 1'b1;
    tick();
    checks++;
    if (inst_valid_o !== 1'b0 || rom_ce_o !== 1'b0 || rom_addr_o !== 32'h0 || pc_o !== 32'h0) begin
      failures++;
      $display("FAIL midrun_reset got v=%b ce=%b addr=%h pc=%h want all zero",
               inst_valid_o, rom_ce_o, rom_addr_o, pc_o);
    end
    rst     = 1'b0;
    stall_i = 1'b0;
  endtask

  task automatic test_random();
    salt = $urandom;
    for (int i = 0; i < 400; i++) begin
      rst             = ($urandom_range(63, 0) == 0);
      stall_i         = ($urandom_range(2, 0) == 0);
      branch_i        = ($urandom_range(15, 0) == 0);
      flush_i         = ($urandom_range(23, 0) == 0);
      branch_target_i = $urandom;
      new_pc_i        = $urandom;
      tick();
      checks++;
      if (obs_s !== exp_vec()) begin
        failures++;
        $display("FAIL random_model cycle=%0d got=%h exp=%h", i, obs_s, exp_vec());
      end
    end
    rst      = 1'b0;
    stall_i  = 1'b0;
    branch_i = 1'b0;
    flush_i  = 1'b0;
  endtask

  initial begin
    salt            = 32'h0;
    rst             = 1'b1;
    stall_i         = 1'b0;
    branch_i        = 1'b0;
    flush_i         = 1'b0;
    branch_target_i = 32'h0;
    new_pc_i        = 32'h0;
    m_run           = 1'b0;
    m_pc            = 32'h0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_branch();
    test_flush_vs_branch();
    test_wrap_and_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
